// File: rtl/packer_pkg.sv
// -----------------------------------------------------------------------------
// packer_pkg
// Shared types and constants for the narrow-beat to wide-word packer.
//   state_t  : FSM states (IDLE, ACCUM, SEND)
//   vbc_t    : valid-byte-count field at the default width
//   beats_f  : input beats per output word
// No ports.
// -----------------------------------------------------------------------------
package packer_pkg;

  localparam int P_IN_SZ_B  = 32;
  localparam int P_OUT_SZ_B = 160;
  localparam int P_VBC_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SEND  = 2'd2
  } state_t;

  typedef logic [P_VBC_W-1:0] vbc_t;

  function automatic int beats_f(input int in_sz_b, input int out_sz_b);
    return out_sz_b / in_sz_b;
  endfunction

endpackage

// File: rtl/packer_if.sv
// -----------------------------------------------------------------------------
// packer_if
// Beat-in / word-out bus of the packer.
//   in_*  : narrow beat stream (val/sop/eop/vbc/data) with in_ready back
//   out_* : wide word stream (val/sop/eop/vbc/data) with out_ready back
// Handshake: a transfer happens on a rising clk edge where valid && ready.
//   The sender keeps valid and its payload stable until that edge; the
//   receiver may raise or drop ready at any time.
// Modports: master = beat source / word sink, slave = the packer.
// -----------------------------------------------------------------------------
interface packer_if
  import packer_pkg::*;
#(
  parameter int IN_SZ_B  = P_IN_SZ_B,
  parameter int OUT_SZ_B = P_OUT_SZ_B,
  parameter int VBC_W    = P_VBC_W
);
  logic                    in_val;
  logic                    in_sop;
  logic                    in_eop;
  logic [VBC_W-1:0]        in_vbc;
  logic [IN_SZ_B*8-1:0]    in_data;
  logic                    in_ready;

  logic                    out_val;
  logic                    out_sop;
  logic                    out_eop;
  logic [VBC_W-1:0]        out_vbc;
  logic [OUT_SZ_B*8-1:0]   out_data;
  logic                    out_ready;

  modport master (
    output in_val, in_sop, in_eop, in_vbc, in_data, out_ready,
    input  in_ready, out_val, out_sop, out_eop, out_vbc, out_data
  );

  modport slave (
    input  in_val, in_sop, in_eop, in_vbc, in_data, out_ready,
    output in_ready, out_val, out_sop, out_eop, out_vbc, out_data
  );
endinterface

// File: rtl/packer_err_chk.sv
// -----------------------------------------------------------------------------
// packer_err_chk
// Input protocol checker for packer_fsm (built only with PACKER_ERR_CHK_EN).
// Ports:
//   clk, reset : clock, async active-high reset
//   i_state    : packer FSM state
//   i_accept   : beat handshake strobe (in_val && in_ready)
//   i_sop/i_eop/i_vbc : sideband of the beat being accepted
//   o_drop     : accepted beat must not be packed
//   o_err      : sticky protocol error, cleared only by reset
// A sop arriving in ACCUM sets err but is not dropped: the packer restarts
// the word on that beat.
// -----------------------------------------------------------------------------
module packer_err_chk
  import packer_pkg::*;
#(
  parameter int IN_SZ_B = P_IN_SZ_B,
  parameter int VBC_W   = P_VBC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  state_t           i_state,
  input  logic             i_accept,
  input  logic             i_sop,
  input  logic             i_eop,
  input  logic [VBC_W-1:0] i_vbc,
  output logic             o_drop,
  output logic             o_err
);
  logic r_err;
  logic w_bad_vbc;
  logic w_idle_nosop;
  logic w_accum_sop;

  assign w_bad_vbc    = (i_vbc == '0) || (i_vbc > VBC_W'(IN_SZ_B)) ||
                        ((i_vbc < VBC_W'(IN_SZ_B)) && !i_eop);
  assign w_idle_nosop = (i_state == IDLE) && !i_sop;
  assign w_accum_sop  = (i_state == ACCUM) && i_sop;

  assign o_drop = i_accept && (w_bad_vbc || w_idle_nosop);
  assign o_err  = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (i_accept && (w_bad_vbc || w_idle_nosop || w_accum_sop)) begin
      r_err <= 1'b1;
    end
  end
endmodule

// File: rtl/packer_fsm.sv
// -----------------------------------------------------------------------------
// packer_fsm
// Packs IN_SZ_B-byte beats into OUT_SZ_B-byte words with val/sop/eop/vbc.
// Ports:
//   clk, reset  : clock, async active-high reset
//   bus         : packer_if.slave (in_* beat stream, out_* word stream)
//   err         : sticky protocol error (0 unless PACKER_ERR_CHK_EN)
//   o_dbg_state : current FSM state
// Optional feature: define PACKER_ERR_CHK_EN to add the input checker.
// -----------------------------------------------------------------------------
module packer_fsm
  import packer_pkg::*;
#(
  parameter int IN_SZ_B  = P_IN_SZ_B,
  parameter int OUT_SZ_B = P_OUT_SZ_B,
  parameter int VBC_W    = P_VBC_W
) (
  input  logic       clk,
  input  logic       reset,
  packer_if.slave    bus,
  output logic       err,
  output state_t     o_dbg_state
);
  localparam int BEATS = beats_f(IN_SZ_B, OUT_SZ_B);
  localparam int IN_W  = IN_SZ_B * 8;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS + 1) : 1;

  state_t                r_state;
  state_t                w_next;
  logic                  r_live;      // holds in_ready low until the first clk after reset
  logic [OUT_SZ_B*8-1:0] r_acc;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [VBC_W-1:0]      r_byte_cnt;
  logic                  r_sop;
  logic                  r_eop;

  logic w_in_ready;
  logic w_out_val;
  logic w_accept;
  logic w_drop;
  logic w_take;
  logic w_restart;
  logic w_start;
  logic w_last;
  logic w_xfer;

  assign w_accept = bus.in_val && w_in_ready;
  assign w_take   = w_accept && !w_drop;

`ifdef PACKER_ERR_CHK_EN
  packer_err_chk #(
    .IN_SZ_B (IN_SZ_B),
    .VBC_W   (VBC_W)
  ) u_err_chk (
    .clk      (clk),
    .reset    (reset),
    .i_state  (r_state),
    .i_accept (w_accept),
    .i_sop    (bus.in_sop),
    .i_eop    (bus.in_eop),
    .i_vbc    (bus.in_vbc),
    .o_drop   (w_drop),
    .o_err    (err)
  );
  // A sop in mid-word abandons the partial word and starts afresh.
  assign w_restart = w_take && (r_state == ACCUM) && bus.in_sop;
`else
  assign w_drop    = 1'b0;
  assign err       = 1'b0;
  assign w_restart = 1'b0;
`endif

  // Beats without sop in IDLE are ignored so a malformed stream cannot wedge us.
  assign w_start = (w_take && (r_state == IDLE) && bus.in_sop) || w_restart;
  assign w_last  = bus.in_eop ||
                   (w_start ? (BEATS == 1) : (r_beat_cnt == CNT_W'(BEATS - 1)));
  assign w_xfer  = (r_state == SEND) && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_out_val  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = r_live;
        if (w_start) w_next = w_last ? SEND : ACCUM;
      end
      ACCUM: begin
        w_in_ready = r_live;
        if (w_take && w_last) w_next = SEND;
      end
      SEND: begin
        w_out_val = 1'b1;
        if (bus.out_ready) w_next = r_eop ? IDLE : ACCUM;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_live     <= 1'b0;
      r_acc      <= '0;
      r_beat_cnt <= '0;
      r_byte_cnt <= '0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_start) begin
        r_acc             <= '0;
        r_acc[IN_W-1:0]   <= bus.in_data;
        r_beat_cnt        <= CNT_W'(1);
        r_byte_cnt        <= bus.in_vbc;
        r_sop             <= 1'b1;
        r_eop             <= bus.in_eop;
      end else if (w_take && (r_state == ACCUM)) begin
        r_acc[int'(r_beat_cnt) * IN_W +: IN_W] <= bus.in_data;
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        r_byte_cnt <= r_byte_cnt + bus.in_vbc;
        r_eop      <= bus.in_eop;
      end else if (w_xfer) begin
        // Clearing here keeps unwritten bytes of the next word at zero.
        r_acc      <= '0;
        r_beat_cnt <= '0;
        r_byte_cnt <= '0;
        r_sop      <= 1'b0;
      end
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.out_val  = w_out_val;
  assign bus.out_sop  = w_out_val && r_sop;
  assign bus.out_eop  = w_out_val && r_eop;
  assign bus.out_vbc  = w_out_val ? r_byte_cnt : '0;
  assign bus.out_data = r_acc;
  assign o_dbg_state  = r_state;
endmodule
